// File: rtl/urv_dmem_wb_bridge.sv
// ---------------------------------------------------------------------------
// urv_dmem_wb_bridge
//   Data-memory responder for the uRV core. Each single-cycle load/store
//   request from the execute stage becomes one Wishbone pipelined-mode
//   transaction. Completion is reported to writeback as a one-cycle done
//   pulse (load or store), qualified by dm_bus_err_o on bus error or timeout.
//
// Parameters
//   g_timeout        cycles with wb_cyc_o high before abort (0 = no timeout)
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   dm_addr_i        byte address from execute
//   dm_data_s_i      store data (already lane-replicated)
//   dm_data_select_i byte-lane select
//   dm_load_i        load request pulse
//   dm_store_i       store request pulse (wins over a simultaneous load)
//   dm_data_l_o      load data, valid with dm_load_done_o
//   dm_load_done_o   load completion pulse
//   dm_store_done_o  store completion pulse
//   dm_bus_err_o     qualifies the done pulse: wb_err_i or timeout
//   dm_busy_o        transaction in flight
//   wb_*             Wishbone pipelined master port
// ---------------------------------------------------------------------------
module urv_dmem_wb_bridge #(
  parameter int unsigned g_timeout = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_bus_err_o,
  output logic        dm_busy_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ACK
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_cyc, w_cyc_nxt;
  logic        r_stb, w_stb_nxt;
  logic        r_we, w_we_nxt;
  logic [31:0] r_adr, w_adr_nxt;
  logic [3:0]  r_sel, w_sel_nxt;
  logic [31:0] r_dat, w_dat_nxt;
  logic [31:0] r_data_l, w_data_l_nxt;
  logic        r_load_done, w_load_done_nxt;
  logic        r_store_done, w_store_done_nxt;
  logic        r_err, w_err_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;

  logic        w_tmo;
  logic        w_end;
  logic        w_fail;

  assign w_tmo = (g_timeout != 32'd0) && (r_cnt == g_timeout);

  always_comb begin
    w_state_nxt      = r_state;
    w_cyc_nxt        = r_cyc;
    w_stb_nxt        = r_stb;
    w_we_nxt         = r_we;
    w_adr_nxt        = r_adr;
    w_sel_nxt        = r_sel;
    w_dat_nxt        = r_dat;
    w_data_l_nxt     = r_data_l;
    w_load_done_nxt  = 1'b0;
    w_store_done_nxt = 1'b0;
    w_err_nxt        = 1'b0;
    w_cnt_nxt        = r_cnt;
    w_end            = 1'b0;
    w_fail           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (dm_load_i || dm_store_i) begin
          w_we_nxt    = dm_store_i;
          w_adr_nxt   = dm_addr_i & 32'hFFFF_FFFC;
          w_sel_nxt   = dm_data_select_i;
          w_dat_nxt   = dm_data_s_i;
          w_cyc_nxt   = 1'b1;
          w_stb_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // Responses seen while the strobe is still pending are ignored.
        if (w_tmo) begin
          w_end  = 1'b1;
          w_fail = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
          if (!wb_stall_i) begin
            w_stb_nxt   = 1'b0;
            w_state_nxt = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_ACK: begin
        // err beats ack; either beats a coincident timeout.
        if (wb_err_i) begin
          w_end  = 1'b1;
          w_fail = 1'b1;
        end else if (wb_ack_i) begin
          w_end = 1'b1;
        end else if (w_tmo) begin
          w_end  = 1'b1;
          w_fail = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_end) begin
      w_cyc_nxt        = 1'b0;
      w_stb_nxt        = 1'b0;
      w_state_nxt      = ST_IDLE;
      w_load_done_nxt  = !r_we;
      w_store_done_nxt = r_we;
      w_err_nxt        = w_fail;
      if (w_fail)
        w_data_l_nxt = '0;
      else if (!r_we)
        w_data_l_nxt = wb_dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_sel        <= '0;
      r_dat        <= '0;
      r_data_l     <= '0;
      r_load_done  <= 1'b0;
      r_store_done <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cyc        <= w_cyc_nxt;
      r_stb        <= w_stb_nxt;
      r_we         <= w_we_nxt;
      r_adr        <= w_adr_nxt;
      r_sel        <= w_sel_nxt;
      r_dat        <= w_dat_nxt;
      r_data_l     <= w_data_l_nxt;
      r_load_done  <= w_load_done_nxt;
      r_store_done <= w_store_done_nxt;
      r_err        <= w_err_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  assign dm_data_l_o     = r_data_l;
  assign dm_load_done_o  = r_load_done;
  assign dm_store_done_o = r_store_done;
  assign dm_bus_err_o    = r_err;
  assign dm_busy_o       = (r_state != ST_IDLE);
  assign wb_cyc_o        = r_cyc;
  assign wb_stb_o        = r_stb;
  assign wb_we_o         = r_we;
  assign wb_adr_o        = r_adr;
  assign wb_sel_o        = r_sel;
  assign wb_dat_o        = r_dat;

endmodule
